hex_scroller: RTL
=================

Name: hex_scroller

Overview:
- Parametrised, clock-driven message scroller for a bank of 7-segment displays.
- Holds a loadable message of MSG_LEN hex symbols and rotates it across NUM_DIGITS displays at a programmable rate, either automatically or by manual step.
- Supports left/right direction and pause.
- Sits between board switches/keys and the HEX display pins; replaces the fixed 3-digit, switch-selected rotation with a timed, generalised one.

Parameters:
- NUM_DIGITS, 3, number of 7-segment displays driven (>=1)
- MSG_LEN, 3, number of symbols in the message (>=1)
- SYM_W, 4, bits per symbol; symbol value is displayed as a hex digit (fixed 4; lower values zero-extended)
- TICK_DIV, 50000000, clock cycles per automatic scroll step (>=1)

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge
- resetn  in  1  asynchronous, active-low reset
- msg_in  in  MSG_LEN*SYM_W  message symbols; symbol k at [k*SYM_W +: SYM_W]
- load  in  1  single-cycle pulse; latch msg_in
- start  in  1  single-cycle pulse; enter RUNNING
- stop  in  1  single-cycle pulse; enter PAUSED
- step  in  1  single-cycle pulse; advance one position, PAUSED only
- dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset-1)
- hex_out  out  NUM_DIGITS*7  active-low segments; digit i at [i*7 +: 7], bit 0 = seg a, bit 6 = seg g; digit 0 drives HEX0
- offset  out  clog2(SEQ_LEN)  current rotation offset
- running  out  1  1 while in RUNNING

Behaviour:
- Clock and reset: one clock, CLOCK_50. resetn is asynchronous and active-low.
- Reset values:
  - msg_reg = 0, offset = 0, prescaler = 0, state = PAUSED, running = 0.
  - hex_out = every digit showing "0" (7'b1000000).
- Sequence length: SEQ_LEN = MSG_LEN, or larger with the optional feature. Position p maps to msg_reg symbol p.
- Display: digit i shows the symbol at position (offset+i) mod SEQ_LEN.
  - If SEQ_LEN < NUM_DIGITS, the message repeats across the digits.
- Segment decode covers 0-F using the standard DE1 active-low hex patterns.
- hex_out is registered: it reflects the offset and msg_reg values of the previous cycle (1-cycle latency).
- FSM, two states:
  - PAUSED -> RUNNING on start, unless stop is also asserted.
  - RUNNING -> PAUSED on stop.
  - stop has priority over start.
- Prescaler:
  - In RUNNING, counts 0..TICK_DIV-1. At TICK_DIV-1 it returns to 0 and the offset advances once.
  - In PAUSED, the prescaler is held at 0.
  - TICK_DIV=1 advances every cycle.
  - The first automatic step after start occurs TICK_DIV cycles after the start edge.
- Manual step: advances the offset once in PAUSED; ignored in RUNNING.
- Offset arithmetic (modulo SEQ_LEN):
  - dir=0: SEQ_LEN-1 -> 0.
  - dir=1: 0 -> SEQ_LEN-1.
  - dir is sampled on the advancing cycle only; changing dir mid-run takes effect at the next step.
- Load:
  - msg_reg <= msg_in, offset <= 0, prescaler <= 0; state is unchanged.
  - load has priority over a coincident step or tick; that advance is dropped.
- Reset mid-run returns everything to reset values immediately, independent of the clock.
- running = (state == RUNNING), registered with state.

Optional Feature:
- Macro: HEX_SCROLLER_BLANK_PAD_EN.
- Defined:
  - SEQ_LEN = MSG_LEN + NUM_DIGITS.
  - Positions MSG_LEN..SEQ_LEN-1 are blanks and display 7'b1111111 (all segments off).
  - The message scrolls fully off the displays before repeating.
- Undefined:
  - SEQ_LEN = MSG_LEN with no blank positions; the message wraps directly.

Test Plan (NUM_DIGITS=3, MSG_LEN=3, TICK_DIV=4, macro undefined unless stated; msg_in symbols 0..2 = 2,5,3):
- Reset then release -> hex_out digits all 7'b1000000, offset=0, running=0.
- load, wait 1 cycle -> digit0=2 (0100100), digit1=5 (0010010), digit2=3 (0110000).
- start, dir=0 -> offset goes 0,1,2,0 at 4, 8, 12 cycles after start; at offset=1 the digits show 5,3,2.
- stop then step twice with dir=1 -> offset goes 0->2->1, running=0; step pulses during RUNNING leave offset unchanged.
- Simultaneous start+stop in PAUSED -> stays PAUSED. load coincident with a tick -> offset=0 and prescaler=0.
- Macro defined, start, dir=0 -> SEQ_LEN=6; at offset=3 all digits show 7'b1111111; at offset=5 the digits show blank,2,5; offset wraps 5->0.

Source files
------------

// File: rtl/hex_scroller.sv
// hex_scroller: rotates a loadable message of hex symbols across a bank of
// active-low 7-segment displays, either on a programmable timer tick
// (RUNNING) or one position per manual step pulse (PAUSED).
//
// Optional feature macro: HEX_SCROLLER_BLANK_PAD_EN
//   When defined, NUM_DIGITS blank positions follow the message so it
//   scrolls fully off the displays before repeating.
//
// Control inputs (load/start/stop/step) are single-cycle pulses sampled on
// the rising edge of CLOCK_50. There is no handshake: each pulse is acted on
// in the cycle it is seen and never back-pressured.
module hex_scroller #(
    parameter int NUM_DIGITS = 3,
    parameter int MSG_LEN    = 3,
    parameter int SYM_W      = 4,
    parameter int TICK_DIV   = 50000000,
`ifdef HEX_SCROLLER_BLANK_PAD_EN
    localparam int SEQ_LEN   = MSG_LEN + NUM_DIGITS,
`else
    localparam int SEQ_LEN   = MSG_LEN,
`endif
    localparam int OFF_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic [MSG_LEN*SYM_W-1:0] msg_in,
    input  logic                     load,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     step,
    input  logic                     dir,
    output logic [NUM_DIGITS*7-1:0]  hex_out,
    output logic [OFF_W-1:0]         offset,
    output logic                     running
);

    localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(SEQ_LEN - 1);
    localparam logic [6:0]       SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [PRE_W-1:0]           presc_q;
    logic [PRE_W-1:0]           presc_d;
    logic                       tick;
    logic                       advance;
    logic [MSG_LEN*SYM_W-1:0]   msg_reg;
    logic [OFF_W-1:0]           off_next;
    logic [NUM_DIGITS*7-1:0]    hex_d;
    int                         pos;
    logic [3:0]                 nib;
    logic                       blank;

    // Active-low segment pattern for one hex digit (bit 0 = seg a).
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // FSM next state, prescaler next value and advance decision.
    // stop beats start; load cancels any advance and clears the prescaler.
    // The prescaler is zero whenever the next state is PAUSED, so the first
    // automatic step lands exactly TICK_DIV cycles after start.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        tick    = 1'b0;
        advance = 1'b0;
        case (state_q)
            PAUSED: begin
                if (start && !stop) begin
                    state_d = RUNNING;
                end
                advance = step;
            end
            RUNNING: begin
                if (stop) begin
                    state_d = PAUSED;
                end
                tick    = (presc_q == PRE_MAX);
                advance = tick;
                if (!tick && state_d == RUNNING) begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            default: state_d = PAUSED;
        endcase
        if (load) begin
            advance = 1'b0;
            presc_d = '0;
        end
    end

    // Next offset in the requested direction, wrapping modulo SEQ_LEN.
    always_comb begin
        off_next = offset;
        if (dir) begin
            off_next = (offset == '0) ? OFF_MAX : offset - OFF_W'(1);
        end else begin
            off_next = (offset == OFF_MAX) ? '0 : offset + OFF_W'(1);
        end
    end

    // Build every digit's segments from the current offset and message.
    // Positions at or beyond MSG_LEN only exist with blank padding enabled.
    always_comb begin
        hex_d = '0;
        pos   = 0;
        nib   = '0;
        blank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pos   = (int'(offset) + i) % SEQ_LEN;
            nib   = '0;
            blank = 1'b1;
            for (int k = 0; k < MSG_LEN; k++) begin
                if (pos == k) begin
                    nib   = 4'(msg_reg[k*SYM_W +: SYM_W]);
                    blank = 1'b0;
                end
            end
            hex_d[i*7 +: 7] = blank ? SEG_BLANK : seg7(nib);
        end
    end

    // FSM state register; running is registered alongside it.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= PAUSED;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= (state_d == RUNNING);
        end
    end

    // Scroll-rate prescaler.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Message latch and rotation offset; load restarts from position 0.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            msg_reg <= '0;
            offset  <= '0;
        end else if (load) begin
            msg_reg <= msg_in;
            offset  <= '0;
        end else if (advance) begin
            offset  <= off_next;
        end
    end

    // Registered segment outputs (one cycle behind offset/msg_reg).
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hex_out <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            hex_out <= hex_d;
        end
    end

endmodule
